prefix_subtractor_pipe: RTL and testbench
=========================================

Name: prefix_subtractor_pipe

Overview:
- Pipelined parallel-prefix (Kogge-Stone) subtractor; inverse operation of the team's prefix adder.
- Computes diff = bits_a - bits_b - borrow_in over BITWIDTH bits and reports borrow, signed overflow and zero flags.
- Two register stages with valid/ready handshake on both sides; sits between operand sources and the ALU result bus.

Parameters:
- BITWIDTH, 8, operand/result width in bits (>= 2).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept an operand beat this cycle.
- bits_a  input  BITWIDTH  minuend.
- bits_b  input  BITWIDTH  subtrahend.
- borrow_in  input  1  incoming borrow (1 = subtract one extra).
- out_valid  output  1  result beat valid.
- out_ready  input  1  downstream accepts result.
- diff  output  BITWIDTH  bits_a - bits_b - borrow_in mod 2^BITWIDTH.
- borrow_out  output  1  1 when unsigned bits_a < bits_b + borrow_in.
- overflow  output  1  signed two's-complement overflow.
- zero  output  1  diff == 0.

Behaviour:
- One clock domain; there is only one clock and one reset.
- Arithmetic: diff = bits_a + ~bits_b + ~borrow_in, carry c0 = ~borrow_in.
- Per bit: g = a & ~b, p = a ^ ~b.
- Carries come from a log2(BITWIDTH)-level Kogge-Stone prefix tree.
- borrow_out = ~c[BITWIDTH].
- overflow = c[BITWIDTH] ^ c[BITWIDTH-1].
- Stage 1 (S1): on accept, registers g, p, c0 and the sign-bit carry inputs. Holds s1_valid.
- Stage 2 (S2): registers diff, borrow_out, overflow and zero computed from the S1 registers through the prefix tree. Holds s2_valid, which drives out_valid.
- Handshake:
  - s2_ready = ~s2_valid | out_ready.
  - in_ready = ~s1_valid | s2_ready. This is combinational, with no dependency on in_valid.
  - Input transfer occurs when in_valid & in_ready.
  - Output transfer occurs when out_valid & out_ready.
- Latency: a beat accepted at edge k presents out_valid after edge k+1 (2 cycles).
- Throughput is 1 beat/cycle when out_ready is held high.
- Stall (out_ready=0 with S2 full):
  - S2 holds all outputs stable.
  - S1 fills if empty, then in_ready=0.
  - Nothing is dropped or duplicated.
- Simultaneous events:
  - When S2 drains and S1 advances in the same cycle, S2 loads the new result. out_valid stays 1 and the beat is not lost.
  - When S1 advances and a new input arrives in the same cycle, S1 reloads.
- Bubbles: if S1 is empty while S2 drains, s2_valid drops to 0 on that edge.
- Data registers update only on transfer. Outputs while out_valid=0 are don't-care, but tests expect reset values until the first result.
- Reset is asynchronous. While rst is asserted, and immediately upon assertion:
  - s1_valid=0, s2_valid=0, out_valid=0.
  - diff=0, borrow_out=0, overflow=0, zero=0.
  - in_ready=1 once rst deasserts (it may be 1 during reset).
- Reset mid-operation discards all in-flight beats. No result emerges for them after release.
- Width rule: every internal node is exactly BITWIDTH wide. c has BITWIDTH+1 bits. There is no sign extension.

Test Plan:
- BITWIDTH=8, single beat a=0x50, b=0x30, bin=0, out_ready=1 -> out_valid 2 cycles later; diff=0x20, borrow_out=0, overflow=0, zero=0.
- a=0x00, b=0x01, bin=0 -> diff=0xFF, borrow_out=1, overflow=0. Then a=0x80, b=0x01, bin=0 -> diff=0x7F, borrow_out=0, overflow=1.
- a=0x05, b=0x04, bin=1 -> diff=0x00, zero=1, borrow_out=0. Then a=0x7F, b=0xFF, bin=0 -> diff=0x80, borrow_out=1, overflow=1.
- Back-to-back stream of 16 beats (random a, b, bin) with out_ready=1 -> 16 results in order, one per cycle, with no bubbles, each matching the reference model.
- Stream of 8 beats with out_ready held 0 for 5 cycles:
  - in_ready falls after 2 accepts.
  - diff stays stable while stalled.
  - After release, all 8 results come out in order with none lost or duplicated.
- rst asserted asynchronously (between edges) with 2 beats in flight -> out_valid=0 and all outputs 0 immediately. After release, no stale result appears, and the next beat returns with 2-cycle latency.

Source files
------------

// File: rtl/prefix_subtractor_pipe_if.sv
// -----------------------------------------------------------------------------
// prefix_subtractor_pipe_if
// Groups the operand-side and result-side handshake/data signals of
// prefix_subtractor_pipe into one bundle.
//   master : operand source / result sink (drives operands and out_ready)
//   slave  : the subtractor (drives in_ready and the result beat)
// Signals:
//   in_valid, in_ready          operand beat handshake
//   bits_a, bits_b, borrow_in   minuend, subtrahend, incoming borrow
//   out_valid, out_ready        result beat handshake
//   diff, borrow_out, overflow, zero   result and flags
// -----------------------------------------------------------------------------
interface prefix_subtractor_pipe_if #(
    parameter int BITWIDTH = 8
);
    logic                in_valid;
    logic                in_ready;
    logic [BITWIDTH-1:0] bits_a;
    logic [BITWIDTH-1:0] bits_b;
    logic                borrow_in;
    logic                out_valid;
    logic                out_ready;
    logic [BITWIDTH-1:0] diff;
    logic                borrow_out;
    logic                overflow;
    logic                zero;

    modport master (
        output in_valid, bits_a, bits_b, borrow_in, out_ready,
        input  in_ready, out_valid, diff, borrow_out, overflow, zero
    );

    modport slave (
        input  in_valid, bits_a, bits_b, borrow_in, out_ready,
        output in_ready, out_valid, diff, borrow_out, overflow, zero
    );
endinterface

// File: rtl/prefix_subtractor_pipe.sv
// -----------------------------------------------------------------------------
// prefix_subtractor_pipe
// Two-stage pipelined Kogge-Stone subtractor:
//   diff = bits_a - bits_b - borrow_in (mod 2^BITWIDTH)
// implemented as bits_a + ~bits_b + ~borrow_in.
// Stage 1 registers per-bit generate/propagate and the carry-in.
// Stage 2 registers the difference and flags produced by the prefix tree.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset, clears both stages and the outputs
//   bus  prefix_subtractor_pipe_if.slave (operand and result handshakes)
// -----------------------------------------------------------------------------
module prefix_subtractor_pipe #(
    parameter int BITWIDTH = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    prefix_subtractor_pipe_if.slave     bus
);
    localparam int LEVELS = $clog2(BITWIDTH);

    // Stage 1 state
    logic                s1_valid_q, s1_valid_d;
    logic [BITWIDTH-1:0] g_q, g_d;
    logic [BITWIDTH-1:0] p_q, p_d;
    logic                c0_q, c0_d;

    // Stage 2 state
    logic                s2_valid_q, s2_valid_d;
    logic [BITWIDTH-1:0] diff_q, diff_d;
    logic                borrow_q, borrow_d;
    logic                overflow_q, overflow_d;
    logic                zero_q, zero_d;

    // Handshake
    logic s2_ready;
    logic in_fire;
    logic s1_advance;

    // Prefix tree nodes
    logic [BITWIDTH-1:0] grp_g;
    logic [BITWIDTH-1:0] grp_p;
    logic [BITWIDTH:0]   carry;

    assign s2_ready   = ~s2_valid_q | bus.out_ready;
    assign bus.in_ready = ~s1_valid_q | s2_ready;
    assign in_fire    = bus.in_valid & bus.in_ready;
    assign s1_advance = s1_valid_q & s2_ready;

    // Kogge-Stone prefix over the registered g/p. At level l each bit
    // combines with the bit 2^l below it; bits below that distance pass
    // through unchanged (shifted-in zeros for g, shifted-in ones for p).
    // grp_g[i]/grp_p[i] end up as the group generate/propagate of bits i..0.
    always_comb begin
        // NOTE: blocking assignments here are intentional: each level reads
        // the previous level's value of the same variable within one pass.
        grp_g = g_q;
        grp_p = p_q;
        for (int l = 0; l < LEVELS; l++) begin
            grp_g = grp_g | (grp_p & (grp_g << (1 << l)));
            grp_p = grp_p & ~(~grp_p << (1 << l));
        end
        carry[0]          = c0_q;
        carry[BITWIDTH:1] = grp_g | (grp_p & {BITWIDTH{c0_q}});
    end

    always_comb begin
        // NOTE: every variable gets a default before any condition, so no
        // path leaves a value unassigned and no latch is inferred.
        s1_valid_d = s1_valid_q;
        g_d        = g_q;
        p_d        = p_q;
        c0_d       = c0_q;
        s2_valid_d = s2_valid_q;
        diff_d     = diff_q;
        borrow_d   = borrow_q;
        overflow_d = overflow_q;
        zero_d     = zero_q;

        // Stage 1: a new beat overrides the drain of the old one, which is
        // what lets S1 reload in the same cycle it advances.
        if (in_fire) begin
            s1_valid_d = 1'b1;
            g_d        = bus.bits_a & ~bus.bits_b;
            p_d        = bus.bits_a ^ ~bus.bits_b;
            c0_d       = ~bus.borrow_in;
        end else if (s1_advance) begin
            s1_valid_d = 1'b0;
        end

        // Stage 2: loading from S1 wins over draining, so a simultaneous
        // drain-and-refill keeps out_valid high without losing the beat.
        if (s1_advance) begin
            s2_valid_d = 1'b1;
            diff_d     = p_q ^ carry[BITWIDTH-1:0];
            borrow_d   = ~carry[BITWIDTH];
            overflow_d = carry[BITWIDTH] ^ carry[BITWIDTH-1];
            zero_d     = ((p_q ^ carry[BITWIDTH-1:0]) == '0);
        end else if (s2_ready) begin
            s2_valid_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            g_q        <= '0;
            p_q        <= '0;
            c0_q       <= 1'b0;
            s2_valid_q <= 1'b0;
            diff_q     <= '0;
            borrow_q   <= 1'b0;
            overflow_q <= 1'b0;
            zero_q     <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            g_q        <= g_d;
            p_q        <= p_d;
            c0_q       <= c0_d;
            s2_valid_q <= s2_valid_d;
            diff_q     <= diff_d;
            borrow_q   <= borrow_d;
            overflow_q <= overflow_d;
            zero_q     <= zero_d;
        end
    end

    assign bus.out_valid  = s2_valid_q;
    assign bus.diff       = diff_q;
    assign bus.borrow_out = borrow_q;
    assign bus.overflow   = overflow_q;
    assign bus.zero       = zero_q;

endmodule

// File: tb/tb_prefix_subtractor_pipe.sv
// -----------------------------------------------------------------------------
// tb_prefix_subtractor_pipe
// Directed self-checking bench for prefix_subtractor_pipe (BITWIDTH = 8).
// Inputs are driven on the falling edge; outputs are sampled 1 time unit
// later, well away from the rising edge.
// -----------------------------------------------------------------------------
module tb_prefix_subtractor_pipe;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    prefix_subtractor_pipe_if #(.BITWIDTH(W)) bus ();

    prefix_subtractor_pipe #(.BITWIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference: packed {zero, overflow, borrow_out, diff} via 9-bit arithmetic.
    function automatic logic [W+2:0] model(input logic [W-1:0] a,
                                           input logic [W-1:0] b,
                                           input logic bin);
        logic [W:0]   full;
        logic [W-1:0] d;
        logic         bo, ov, z;
        full = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
        d    = full[W-1:0];
        bo   = full[W];
        ov   = (a[W-1] != b[W-1]) && (d[W-1] != a[W-1]);
        z    = (d == '0);
        return {z, ov, bo, d};
    endfunction

    function automatic logic [W+2:0] observed();
        return {bus.zero, bus.overflow, bus.borrow_out, bus.diff};
    endfunction

    task automatic idle_inputs();
        bus.in_valid  = 1'b0;
        bus.bits_a    = '0;
        bus.bits_b    = '0;
        bus.borrow_in = 1'b0;
        bus.out_ready = 1'b1;
    endtask

    // One beat through an empty pipe: checks latency, result, and no repeat.
    task automatic single_beat(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic bin, input logic [W+2:0] exp,
                               input string name);
        @(negedge clk);
        bus.in_valid = 1'b1; bus.bits_a = a; bus.bits_b = b;
        bus.borrow_in = bin; bus.out_ready = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL %s in_ready got %b want 1", name, bus.in_ready);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL %s early out_valid got %b want 0", name, bus.out_valid);
        end
        @(negedge clk);
        #1;
        checks++;
        if (bus.out_valid !== 1'b1) begin
            errors++; $display("FAIL %s out_valid got %b want 1", name, bus.out_valid);
        end
        checks++;
        if (observed() !== exp) begin
            errors++; $display("FAIL %s {z,ov,bo,diff} got %h want %h", name, observed(), exp);
        end
        @(negedge clk);
        #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL %s repeat out_valid got %b want 0", name, bus.out_valid);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        #2;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL reset out_valid got %b want 0", bus.out_valid);
        end
        checks++;
        if (observed() !== '0) begin
            errors++; $display("FAIL reset outputs got %h want 0", observed());
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL reset in_ready got %b want 1", bus.in_ready);
        end
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL post-reset out_valid got %b want 0", bus.out_valid);
        end
    endtask

    task automatic test_basic();
        single_beat(8'h50, 8'h30, 1'b0, {1'b0, 1'b0, 1'b0, 8'h20}, "sub_50_30");
    endtask

    task automatic test_borrow_overflow();
        single_beat(8'h00, 8'h01, 1'b0, {1'b0, 1'b0, 1'b1, 8'hFF}, "borrow_00_01");
        single_beat(8'h80, 8'h01, 1'b0, {1'b0, 1'b1, 1'b0, 8'h7F}, "ovf_80_01");
    endtask

    task automatic test_zero_and_both();
        single_beat(8'h05, 8'h04, 1'b1, {1'b1, 1'b0, 1'b0, 8'h00}, "zero_05_04_b1");
        single_beat(8'h7F, 8'hFF, 1'b0, {1'b0, 1'b1, 1'b1, 8'h80}, "both_7F_FF");
    endtask

    task automatic test_back_to_back();
        logic [W-1:0]   va [16];
        logic [W-1:0]   vb [16];
        logic           vbin [16];
        logic [W+2:0]   exp_q [$];
        logic [W+2:0]   e;
        int             sent = 0;
        int             recv = 0;
        bit             started = 0;
        for (int i = 0; i < 16; i++) begin
            va[i]   = W'($urandom_range(0, 255));
            vb[i]   = W'($urandom_range(0, 255));
            vbin[i] = 1'($urandom_range(0, 1));
        end
        for (int cyc = 0; cyc < 40 && recv < 16; cyc++) begin
            @(negedge clk);
            bus.out_ready = 1'b1;
            if (sent < 16) begin
                bus.in_valid = 1'b1; bus.bits_a = va[sent];
                bus.bits_b = vb[sent]; bus.borrow_in = vbin[sent];
            end else begin
                bus.in_valid = 1'b0;
            end
            #1;
            if (bus.out_valid === 1'b1) begin
                started = 1;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL b2b unexpected beat got %h want none", observed());
                end else begin
                    e = exp_q.pop_front();
                    if (observed() !== e) begin
                        errors++; $display("FAIL b2b beat %0d got %h want %h", recv, observed(), e);
                    end
                end
                recv++;
            end else if (started) begin
                checks++; errors++;
                $display("FAIL b2b bubble after %0d beats got out_valid 0 want 1", recv);
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(model(va[sent], vb[sent], vbin[sent]));
                sent++;
            end
        end
        bus.in_valid = 1'b0;
        checks++;
        if (recv !== 16) begin
            errors++; $display("FAIL b2b count got %0d want 16", recv);
        end
    endtask

    task automatic test_stall();
        logic [W-1:0]   va [8];
        logic [W-1:0]   vb [8];
        logic           vbin [8];
        logic [W+2:0]   exp_q [$];
        logic [W+2:0]   e;
        int             sent = 0;
        int             recv = 0;
        for (int i = 0; i < 8; i++) begin
            va[i]   = W'(8'h11 * (i + 1));
            vb[i]   = W'(8'h23 * i + 8'h05);
            vbin[i] = 1'(i & 1);
        end
        for (int cyc = 0; cyc < 60 && recv < 8; cyc++) begin
            @(negedge clk);
            bus.out_ready = (cyc >= 5);
            if (sent < 8) begin
                bus.in_valid = 1'b1; bus.bits_a = va[sent];
                bus.bits_b = vb[sent]; bus.borrow_in = vbin[sent];
            end else begin
                bus.in_valid = 1'b0;
            end
            #1;
            if (cyc == 2) begin
                checks++;
                if (sent !== 2) begin
                    errors++; $display("FAIL stall accepts before full got %0d want 2", sent);
                end
            end
            if (cyc >= 2 && cyc <= 4) begin
                checks++;
                if (bus.in_ready !== 1'b0) begin
                    errors++; $display("FAIL stall in_ready cyc %0d got %b want 0", cyc, bus.in_ready);
                end
                checks++;
                if (bus.out_valid !== 1'b1 || bus.diff !== model(va[0], vb[0], vbin[0])) begin
                    errors++;
                    $display("FAIL stall hold cyc %0d got v=%b diff=%h want v=1 diff=%h",
                             cyc, bus.out_valid, bus.diff, model(va[0], vb[0], vbin[0]));
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL stall unexpected beat got %h want none", observed());
                end else begin
                    e = exp_q.pop_front();
                    if (observed() !== e) begin
                        errors++; $display("FAIL stall beat %0d got %h want %h", recv, observed(), e);
                    end
                end
                recv++;
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(model(va[sent], vb[sent], vbin[sent]));
                sent++;
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        checks++;
        if (recv !== 8) begin
            errors++; $display("FAIL stall count got %0d want 8", recv);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (bus.out_valid !== 1'b0) begin
                errors++; $display("FAIL stall duplicate beat got out_valid %b want 0", bus.out_valid);
            end
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.bits_a = 8'h7F; bus.bits_b = 8'hFF; bus.borrow_in = 1'b0;
        @(negedge clk);
        bus.bits_a = 8'h10; bus.bits_b = 8'h20; bus.borrow_in = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b1 || observed() !== {1'b0, 1'b1, 1'b1, 8'h80}) begin
            errors++;
            $display("FAIL arst pre-state got v=%b %h want v=1 %h",
                     bus.out_valid, observed(), {1'b0, 1'b1, 1'b1, 8'h80});
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL arst out_valid got %b want 0", bus.out_valid);
        end
        checks++;
        if (observed() !== '0) begin
            errors++; $display("FAIL arst outputs got %h want 0", observed());
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (bus.out_valid !== 1'b0) begin
                errors++; $display("FAIL arst stale beat cyc %0d got out_valid %b want 0", i, bus.out_valid);
            end
        end
        single_beat(8'h10, 8'h01, 1'b0, {1'b0, 1'b0, 1'b0, 8'h0F}, "arst_next_beat");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_borrow_overflow();
        test_zero_and_both();
        test_back_to_back();
        test_stall();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
